// File: rtl/hazard_pkg.sv
// Shared helpers for the hazard/stall controller.
// Stage bits of pause/bubble/flush vectors: bit NSTAGE-1 is ID, and the lower
// bits are progressively older stages (EX, MEM, ...).
package hazard_pkg;

  // Bit position of each named stage within an NSTAGE-wide stage vector.
  function automatic int stg_id(input int nstage);
    return nstage - 1;
  endfunction

  function automatic int stg_ex(input int nstage);
    return nstage - 2;
  endfunction

  function automatic int stg_mem(input int nstage);
    return nstage - 3;
  endfunction

  // Register-index width, never narrower than one bit.
  function automatic int reg_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for multi-cycle (mul/div) results.
// Each entry holds the number of cycles until its result is available.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   issue/issue_rd/lat  start a countdown for issue_rd (lat 0 counts as 1)
//   done/done_rd        result written back, clear the entry
//   kill                clear every entry (beats a same-cycle issue)
//   busy                per-register "result still pending" flags
module hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int RW   = 5,
  parameter int LW   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue,
  input  logic [RW-1:0]   issue_rd,
  input  logic [LW-1:0]   issue_lat,
  input  logic            done,
  input  logic [RW-1:0]   done_rd,
  input  logic            kill,
  output logic [NREG-1:0] busy
);

  logic [LW-1:0] cnt [NREG];
  logic [LW-1:0] lat_eff;

  assign lat_eff = (issue_lat == '0) ? LW'(1) : issue_lat;

  // NOTE: the array is tiny and its contents gate stalls directly, so every
  // entry is reset; an unreset entry would stall on garbage after power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      // Entry 0 is x0 and keeps its reset value forever.
      for (int r = 1; r < NREG; r++) begin
        // NOTE: non-blocking assignments keep every entry updating from the
        // same pre-edge values, independent of statement order.
        if (kill)                                cnt[r] <= '0;
        else if (issue && issue_rd == RW'(r))    cnt[r] <= lat_eff;
        else if (done && done_rd == RW'(r))      cnt[r] <= '0;
        else if (cnt[r] != '0)                   cnt[r] <= cnt[r] - LW'(1);
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) busy[r] = (cnt[r] != '0);
  end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Hazard/stall controller for an NSTAGE in-order pipeline with a multi-cycle
// result scoreboard, WAW checks, x0 masking, flush priority and a saturating
// stall-cycle counter.
// Ports:
//   id_*         ID-stage sources/destination and multi-cycle flag
//   ex_*         EX destination, load, redirect, multi-cycle issue + latency
//   wb_mc_*      multi-cycle writeback; mc_kill cancels all pending results
//   flush        per-stage flush request; s_exception flushes from MEM
//   pc_pause     hold PC; pause/bubble per stage (bit NSTAGE-1 = ID)
//   mc_busy      any multi-cycle result pending; stall_cnt saturating count
module hazard_ctrl_sb
  import hazard_pkg::*;
#(
  parameter int NSTAGE  = 4,
  parameter int NREG    = 32,
  parameter int RW      = reg_w(NREG),
  parameter int LW      = 3,
  parameter int MC_PIPE = 0,
  parameter int CW      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RW-1:0]     id_rs1,
  input  logic [RW-1:0]     id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [RW-1:0]     id_rd,
  input  logic              id_we,
  input  logic              id_mc,
  input  logic [RW-1:0]     ex_rd,
  input  logic              ex_load,
  input  logic              ex_jump,
  input  logic              ex_mc_valid,
  input  logic [LW-1:0]     ex_mc_lat,
  input  logic              wb_mc_done,
  input  logic [RW-1:0]     wb_mc_rd,
  input  logic              mc_kill,
  input  logic [NSTAGE-1:0] flush,
  input  logic              s_exception,
  output logic              pc_pause,
  output logic [NSTAGE-1:0] pause,
  output logic [NSTAGE-1:0] bubble,
  output logic              mc_busy,
  output logic [CW-1:0]     stall_cnt
);

  localparam int STG_ID  = stg_id(NSTAGE);
  localparam int STG_EX  = stg_ex(NSTAGE);
  localparam int STG_MEM = stg_mem(NSTAGE);

  logic [NSTAGE-1:0] kill_vec;
  logic [NREG-1:0]   sb_busy;
  logic              any_kill;
  logic              load_use, sb_raw, sb_waw, struct_hz, stall;
  logic              mc_issue;

  assign kill_vec = flush
                  | (NSTAGE'(ex_jump)     << STG_EX)
                  | (NSTAGE'(s_exception) << STG_MEM);
  assign any_kill = |kill_vec;

  // A multi-cycle op only issues if EX and everything older survive.
  assign mc_issue = ex_mc_valid && (kill_vec[STG_EX:0] == '0) && (ex_rd != '0);

  hazard_scoreboard #(.NREG(NREG), .RW(RW), .LW(LW)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (mc_issue),
    .issue_rd  (ex_rd),
    .issue_lat (ex_mc_lat),
    .done      (wb_mc_done),
    .done_rd   (wb_mc_rd),
    .kill      (mc_kill),
    .busy      (sb_busy)
  );

  assign mc_busy = |sb_busy;

  // x0 never carries a dependency.
  assign load_use  = ex_load && (ex_rd != '0) &&
                     ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  assign sb_raw    = (id_use_rs1 && id_rs1 != '0 && sb_busy[id_rs1]) ||
                     (id_use_rs2 && id_rs2 != '0 && sb_busy[id_rs2]);
  assign sb_waw    = id_we && (id_rd != '0) && sb_busy[id_rd];
  assign struct_hz = id_mc && mc_busy && (MC_PIPE == 0);
  assign stall     = !any_kill && (load_use || sb_raw || sb_waw || struct_hz);

  // Flush beats stall: the oldest flushed stage and everything younger get
  // bubbles, so a running OR from bit 0 upward marks bits >= lowest set bit.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    logic acc;
    acc      = 1'b0;
    pc_pause = 1'b0;
    pause    = '0;
    bubble   = '0;
    if (any_kill) begin
      pc_pause = 1'b1;
      for (int i = 0; i < NSTAGE; i++) begin
        acc       = acc | kill_vec[i];
        bubble[i] = acc;
      end
    end else if (stall) begin
      pc_pause       = 1'b1;
      pause[STG_ID]  = 1'b1;
      bubble[STG_EX] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         stall_cnt <= '0;
    else if (stall && stall_cnt != '1)  stall_cnt <= stall_cnt + CW'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Randomised + directed bench for hazard_ctrl_sb. Two instances share inputs:
// dut0 (non-pipelined multi-cycle unit) and dut1 (pipelined), both with a
// 4-bit stall counter. A behavioural model tracks remaining latency per
// register and derives the expected controls from the hazard rules.
module tb_hazard_ctrl_sb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, wb_mc_rd;
  logic       id_use_rs1, id_use_rs2, id_we, id_mc;
  logic       ex_load, ex_jump, ex_mc_valid, wb_mc_done, mc_kill, s_exception;
  logic [2:0] ex_mc_lat;
  logic [3:0] flush;

  logic       pc_pause0, pc_pause1, mc_busy0, mc_busy1;
  logic [3:0] pause0, pause1, bubble0, bubble1, stall_cnt0, stall_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cycles remaining until each register's result is ready.
  int sb_left [32];
  int m_cnt   [2];

  always #5 clk = ~clk;

  hazard_ctrl_sb #(.NSTAGE(4), .NREG(32), .LW(3), .MC_PIPE(0), .CW(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_mc(id_mc), .ex_rd(ex_rd), .ex_load(ex_load), .ex_jump(ex_jump),
    .ex_mc_valid(ex_mc_valid), .ex_mc_lat(ex_mc_lat), .wb_mc_done(wb_mc_done),
    .wb_mc_rd(wb_mc_rd), .mc_kill(mc_kill), .flush(flush), .s_exception(s_exception),
    .pc_pause(pc_pause0), .pause(pause0), .bubble(bubble0), .mc_busy(mc_busy0),
    .stall_cnt(stall_cnt0)
  );

  hazard_ctrl_sb #(.NSTAGE(4), .NREG(32), .LW(3), .MC_PIPE(1), .CW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_mc(id_mc), .ex_rd(ex_rd), .ex_load(ex_load), .ex_jump(ex_jump),
    .ex_mc_valid(ex_mc_valid), .ex_mc_lat(ex_mc_lat), .wb_mc_done(wb_mc_done),
    .wb_mc_rd(wb_mc_rd), .mc_kill(mc_kill), .flush(flush), .s_exception(s_exception),
    .pc_pause(pc_pause1), .pause(pause1), .bubble(bubble1), .mc_busy(mc_busy1),
    .stall_cnt(stall_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_rd = '0; wb_mc_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_we = 0; id_mc = 0;
    ex_load = 0; ex_jump = 0; ex_mc_valid = 0; ex_mc_lat = '0;
    wb_mc_done = 0; mc_kill = 0; flush = '0; s_exception = 0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) sb_left[r] = 0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  function automatic logic [3:0] kill_m();
    return flush | (ex_jump ? 4'b0100 : 4'b0000) | (s_exception ? 4'b0010 : 4'b0000);
  endfunction

  function automatic bit pending(input logic [4:0] r);
    return (r != 0) && (sb_left[r] > 0);
  endfunction

  function automatic bit any_pending();
    for (int r = 0; r < 32; r++) if (sb_left[r] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Expected controls for the current inputs and model state.
  task automatic model_out(input bit pipe, output logic pcp, output logic [3:0] pz,
                           output logic [3:0] bz, output bit st);
    logic [3:0] k;
    int low;
    bit lu, raw, waw, sh;
    k = kill_m();
    pcp = 0; pz = '0; bz = '0; st = 0; low = 0;
    if (k != 0) begin
      for (int i = 3; i >= 0; i--) if (k[i]) low = i;
      bz  = 4'hF << low;
      pcp = 1;
    end else begin
      lu  = ex_load && ex_rd != 0 &&
            ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      raw = (id_use_rs1 && pending(id_rs1)) || (id_use_rs2 && pending(id_rs2));
      waw = id_we && pending(id_rd);
      sh  = id_mc && any_pending() && !pipe;
      st  = lu || raw || waw || sh;
      if (st) begin
        pcp = 1; pz = 4'b1000; bz = 4'b0100;
      end
    end
  endtask

  task automatic model_update();
    logic pcp;
    logic [3:0] pz, bz, k;
    bit st0, st1, issue;
    int lat;
    model_out(1'b0, pcp, pz, bz, st0);
    model_out(1'b1, pcp, pz, bz, st1);
    if (st0 && m_cnt[0] < 15) m_cnt[0]++;
    if (st1 && m_cnt[1] < 15) m_cnt[1]++;
    k     = kill_m();
    issue = ex_mc_valid && k[2:0] == 0 && ex_rd != 0;
    lat   = (ex_mc_lat == 0) ? 1 : int'(ex_mc_lat);
    for (int r = 1; r < 32; r++) begin
      if (mc_kill)                         sb_left[r] = 0;
      else if (issue && r == int'(ex_rd))  sb_left[r] = lat;
      else if (wb_mc_done && r == int'(wb_mc_rd)) sb_left[r] = 0;
      else if (sb_left[r] > 0)             sb_left[r]--;
    end
  endtask

  // Compare both instances at the falling edge, then advance one cycle.
  task automatic step();
    logic pcp;
    logic [3:0] pz, bz;
    bit st;
    @(negedge clk);
    model_out(1'b0, pcp, pz, bz, st);
    check("pc_pause0", 32'(pc_pause0), 32'(pcp));
    check("pause0",    32'(pause0),    32'(pz));
    check("bubble0",   32'(bubble0),   32'(bz));
    model_out(1'b1, pcp, pz, bz, st);
    check("pc_pause1", 32'(pc_pause1), 32'(pcp));
    check("pause1",    32'(pause1),    32'(pz));
    check("bubble1",   32'(bubble1),   32'(bz));
    check("mc_busy0",  32'(mc_busy0),  32'(any_pending()));
    check("mc_busy1",  32'(mc_busy1),  32'(any_pending()));
    check("stall_cnt0", 32'(stall_cnt0), 32'(m_cnt[0]));
    check("stall_cnt1", 32'(stall_cnt1), 32'(m_cnt[1]));
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    int saved;
    clear_inputs();
    model_reset();
    rst_n = 1'b0;
    #12;
    check("rst_busy",  32'(mc_busy0),   32'd0);
    check("rst_cnt",   32'(stall_cnt0), 32'd0);
    check("rst_pause", 32'(pause0),     32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load-use on rs1, then the same pattern targeting x0.
    ex_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1;
    check("lu_pause",    32'(pause0),    32'b1000);
    check("lu_bubble",   32'(bubble0),   32'b0100);
    check("lu_pc_pause", 32'(pc_pause0), 32'd1);
    step();
    ex_rd = 0; id_rs1 = 0;
    #1;
    check("lu_x0_pc_pause", 32'(pc_pause0), 32'd0);
    step();

    // Multi-cycle RAW: lat 3 stalls ID for three cycles.
    clear_inputs();
    ex_mc_valid = 1; ex_rd = 7; ex_mc_lat = 3;
    step();
    clear_inputs();
    id_rs1 = 7; id_use_rs1 = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("raw_hold", 32'(pause0[3]), 32'(i < 3));
      step();
    end

    // Early release through writeback.
    clear_inputs();
    ex_mc_valid = 1; ex_rd = 7; ex_mc_lat = 3;
    step();
    clear_inputs();
    id_rs1 = 7; id_use_rs1 = 1;
    step();
    wb_mc_done = 1; wb_mc_rd = 7;
    #1;
    check("early_still", 32'(pause0[3]), 32'd1);
    step();
    wb_mc_done = 0;
    #1;
    check("early_free", 32'(pause0[3]), 32'd0);
    step();

    // Flush priority over a load-use hazard; counter must not move.
    clear_inputs();
    ex_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; ex_jump = 1;
    #1;
    check("jmp_bubble", 32'(bubble0), 32'b1100);
    check("jmp_pause",  32'(pause0),  32'b0000);
    saved = m_cnt[0];
    step();
    check("jmp_cnt_hold", 32'(stall_cnt0), 32'(saved));
    clear_inputs();
    s_exception = 1; flush = 4'b1000;
    #1;
    check("exc_bubble", 32'(bubble0), 32'b1110);
    step();

    // Kill beats issue; an EX flush suppresses issue.
    clear_inputs();
    ex_mc_valid = 1; ex_rd = 9; ex_mc_lat = 5; mc_kill = 1;
    step();
    check("kill_issue", 32'(mc_busy0), 32'd0);
    clear_inputs();
    ex_mc_valid = 1; ex_rd = 9; ex_mc_lat = 5; flush = 4'b0100;
    step();
    check("flush_issue", 32'(mc_busy0), 32'd0);

    // Structural hazard only when the unit is not pipelined.
    clear_inputs();
    ex_mc_valid = 1; ex_rd = 3; ex_mc_lat = 7;
    step();
    clear_inputs();
    id_mc = 1;
    #1;
    check("struct_np", 32'(pause0), 32'b1000);
    check("struct_p",  32'(pause1), 32'b0000);
    step();
    clear_inputs();
    mc_kill = 1;
    step();

    // Randomised traffic on a small register window to provoke overlaps.
    for (int n = 0; n < 600; n++) begin
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_rd       = 5'($urandom_range(0, 7));
      ex_rd       = 5'($urandom_range(0, 7));
      wb_mc_rd    = 5'($urandom_range(0, 7));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      id_we       = 1'($urandom_range(0, 1));
      id_mc       = ($urandom_range(0, 3) == 0);
      ex_load     = ($urandom_range(0, 3) == 0);
      ex_jump     = ($urandom_range(0, 7) == 0);
      ex_mc_valid = ($urandom_range(0, 2) == 0);
      ex_mc_lat   = 3'($urandom_range(0, 7));
      wb_mc_done  = ($urandom_range(0, 3) == 0);
      mc_kill     = ($urandom_range(0, 15) == 0);
      s_exception = ($urandom_range(0, 15) == 0);
      flush       = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      step();
    end

    // Asynchronous reset in the middle of a pending op.
    clear_inputs();
    ex_mc_valid = 1; ex_rd = 7; ex_mc_lat = 2;
    step();
    clear_inputs();
    check("pre_rst_busy", 32'(mc_busy0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(mc_busy0),   32'd0);
    check("mid_rst_cnt0", 32'(stall_cnt0), 32'd0);
    check("mid_rst_cnt1", 32'(stall_cnt1), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Counter saturation with a 4-bit width.
    ex_load = 1; ex_rd = 4; id_rs2 = 4; id_use_rs2 = 1;
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt0", 32'(stall_cnt0), 32'd15);
    check("sat_cnt1", 32'(stall_cnt1), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
